// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants for instr_encoder and the decode path:
// command kinds, opcodes, funct3/funct7 values, ALU function codes, and
// the per-format word builders and immediate range helpers.
package instr_encoder_pkg;

    localparam int N               = 32;
    localparam int ALU_FUNCT_WIDTH = 4;

    typedef enum logic [3:0] {
        KIND_ALU_REG = 4'd0,
        KIND_ALU_IMM = 4'd1,
        KIND_LOAD    = 4'd2,
        KIND_STORE   = 4'd3,
        KIND_BRANCH  = 4'd4,
        KIND_JAL     = 4'd5,
        KIND_JALR    = 4'd6,
        KIND_LUI     = 4'd7,
        KIND_LI      = 4'd8,
        KIND_ECOL    = 4'd9
    } cmd_kind_e;

    typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_funct_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_LI_LO = 1'b1
    } state_e;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    // Xedgcol custom-0 opcode, shared with the decoder.
    localparam logic [6:0] OPC_XEDGCOL = 7'b0001011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Command as seen by the field packer (after LI expansion).
    typedef struct packed {
        logic [3:0]                 kind;
        logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
        logic [2:0]                 funct3;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [4:0]                 rd;
        logic [N-1:0]               immed;
    } enc_cmd_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } alu_map_t;

    function automatic alu_map_t alu_map(input logic [ALU_FUNCT_WIDTH-1:0] f);
        alu_map_t m;
        m = '{valid: 1'b1, funct3: F3_ADD_SUB, funct7: F7_BASE};
        case (f)
            ALU_ADD:  m.funct3 = F3_ADD_SUB;
            ALU_SUB:  begin m.funct3 = F3_ADD_SUB; m.funct7 = F7_ALT; end
            ALU_SLL:  m.funct3 = F3_SLL;
            ALU_SLT:  m.funct3 = F3_SLT;
            ALU_SLTU: m.funct3 = F3_SLTU;
            ALU_XOR:  m.funct3 = F3_XOR;
            ALU_SRL:  m.funct3 = F3_SRL_SRA;
            ALU_SRA:  begin m.funct3 = F3_SRL_SRA; m.funct7 = F7_ALT; end
            ALU_OR:   m.funct3 = F3_OR;
            ALU_AND:  m.funct3 = F3_AND;
            default:  m.valid = 1'b0;
        endcase
        return m;
    endfunction

    function automatic logic fits_s12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

    function automatic logic fits_s13(input logic [31:0] v);
        return (v[31:12] == '0) || (v[31:12] == '1);
    endfunction

    function automatic logic fits_s21(input logic [31:0] v);
        return (v[31:20] == '0) || (v[31:20] == '1);
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [6:0] opc);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm, rd, opc};
    endfunction

    function automatic logic [31:0] j_type(input logic [20:1] imm, input logic [4:0] rd,
                                           input logic [6:0] opc);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command and instruction-word streams of instr_encoder.
// master: sequencer side (issues commands, consumes words).
// slave:  the encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [3:0]                 cmd_kind;
    logic [ALU_FUNCT_WIDTH-1:0] cmd_alu_funct;
    logic [2:0]                 cmd_funct3;
    logic [4:0]                 cmd_rs1;
    logic [4:0]                 cmd_rs2;
    logic [4:0]                 cmd_rd;
    logic [N-1:0]               cmd_immed;
    logic                       instr_valid;
    logic                       instr_ready;
    logic [31:0]                instr;
    logic                       enc_err;

    modport master (
        output cmd_valid, cmd_kind, cmd_alu_funct, cmd_funct3,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_immed, instr_ready,
        input  cmd_ready, instr_valid, instr, enc_err
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_alu_funct, cmd_funct3,
               cmd_rs1, cmd_rs2, cmd_rd, cmd_immed, instr_ready,
        output cmd_ready, instr_valid, instr, enc_err
    );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational packing of one command into an RV32I word (R/I/S/B/U/J),
// with a flag for illegal commands or out-of-range immediates.
// XEDGCOL_EN: when defined, KIND_ECOL encodes the Xedgcol ECOL instruction;
// otherwise it is rejected.
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  enc_cmd_t    cmd,
    output logic [31:0] word,
    output logic        range_err
);

    alu_map_t alu;
    logic     is_shift;

    assign alu      = alu_map(cmd.alu_funct);
    assign is_shift = (cmd.alu_funct == ALU_SLL) || (cmd.alu_funct == ALU_SRL) ||
                      (cmd.alu_funct == ALU_SRA);

    // Select format by kind and check the immediate range.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        word      = '0;
        range_err = 1'b0;
        case (cmd.kind)
            KIND_ALU_REG: begin
                if (!alu.valid) range_err = 1'b1;
                else word = r_type(alu.funct7, cmd.rs2, cmd.rs1, alu.funct3, cmd.rd, OPC_OP);
            end
            KIND_ALU_IMM: begin
                if (!alu.valid || cmd.alu_funct == ALU_SUB) begin
                    range_err = 1'b1;
                end else if (is_shift) begin
                    if (cmd.immed[31:5] != '0) range_err = 1'b1;
                    else word = i_type({alu.funct7, cmd.immed[4:0]}, cmd.rs1,
                                       alu.funct3, cmd.rd, OPC_OP_IMM);
                end else if (!fits_s12(cmd.immed)) begin
                    range_err = 1'b1;
                end else begin
                    word = i_type(cmd.immed[11:0], cmd.rs1, alu.funct3, cmd.rd, OPC_OP_IMM);
                end
            end
            KIND_LOAD: begin
                if (!fits_s12(cmd.immed)) range_err = 1'b1;
                else word = i_type(cmd.immed[11:0], cmd.rs1, cmd.funct3, cmd.rd, OPC_LOAD);
            end
            KIND_STORE: begin
                if (!fits_s12(cmd.immed)) range_err = 1'b1;
                else word = s_type(cmd.immed[11:0], cmd.rs2, cmd.rs1, cmd.funct3, OPC_STORE);
            end
            KIND_BRANCH: begin
                if (!fits_s13(cmd.immed) || cmd.immed[0]) range_err = 1'b1;
                else word = b_type(cmd.immed[12:1], cmd.rs2, cmd.rs1, cmd.funct3, OPC_BRANCH);
            end
            KIND_JAL: begin
                if (!fits_s21(cmd.immed) || cmd.immed[0]) range_err = 1'b1;
                else word = j_type(cmd.immed[20:1], cmd.rd, OPC_JAL);
            end
            KIND_JALR: begin
                if (!fits_s12(cmd.immed)) range_err = 1'b1;
                else word = i_type(cmd.immed[11:0], cmd.rs1, F3_JALR, cmd.rd, OPC_JALR);
            end
            KIND_LUI: begin
                if (cmd.immed[11:0] != '0) range_err = 1'b1;
                else word = u_type(cmd.immed[31:12], cmd.rd, OPC_LUI);
            end
`ifdef XEDGCOL_EN
            KIND_ECOL: begin
                word = r_type(F7_BASE, cmd.rs2, cmd.rs1, 3'b000, 5'd0, OPC_XEDGCOL);
            end
`else
            KIND_ECOL: begin
                range_err = 1'b1;
            end
`endif
            // LI is expanded upstream; it and undefined kinds are rejected here.
            default: range_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts decoded-form commands and emits
// instruction words on a registered valid/ready stream. LI expands to a
// single ADDI, or LUI followed by ADDI when the low part is non-zero.
// XEDGCOL_EN: enables encoding of KIND_ECOL (see instr_field_pack).
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    instr_encoder_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] instr_q;
    logic        instr_valid_q;
    logic        enc_err_q;
    logic [4:0]  li_rd_q;
    logic [11:0] li_lo_q;

    logic        slot_free;
    logic        accept;
    logic        li_fits;
    logic        li_need_lo;
    logic [19:0] li_hi;
    logic        load;
    logic        err_d;
    logic        li_latch;

    enc_cmd_t    req;
    logic [31:0] pack_word;
    logic        pack_err;

    assign slot_free     = !instr_valid_q || bus.instr_ready;
    assign bus.cmd_ready = (state_q == ST_IDLE) && slot_free;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // LI split: hi absorbs the borrow from the sign-extended low 12 bits.
    assign li_fits    = fits_s12(bus.cmd_immed);
    assign li_hi      = bus.cmd_immed[31:12] + {19'd0, bus.cmd_immed[11]};
    assign li_need_lo = (bus.cmd_immed[11:0] != 12'd0);

    // Choose what the packer encodes this cycle: the command, its LI expansion, or the pending ADDI.
    always_comb begin
        req.kind      = bus.cmd_kind;
        req.alu_funct = bus.cmd_alu_funct;
        req.funct3    = bus.cmd_funct3;
        req.rs1       = bus.cmd_rs1;
        req.rs2       = bus.cmd_rs2;
        req.rd        = bus.cmd_rd;
        req.immed     = bus.cmd_immed;
        if (state_q == ST_LI_LO) begin
            req.kind      = KIND_ALU_IMM;
            req.alu_funct = ALU_ADD;
            req.rs1       = li_rd_q;
            req.rd        = li_rd_q;
            req.immed     = {{20{li_lo_q[11]}}, li_lo_q};
        end else if (bus.cmd_kind == KIND_LI) begin
            if (li_fits) begin
                req.kind      = KIND_ALU_IMM;
                req.alu_funct = ALU_ADD;
                req.rs1       = 5'd0;
            end else begin
                req.kind  = KIND_LUI;
                req.immed = {li_hi, 12'd0};
            end
        end
    end

    instr_field_pack u_pack (
        .cmd       (req),
        .word      (pack_word),
        .range_err (pack_err)
    );

    // Next-state and output-register control.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        err_d    = 1'b0;
        li_latch = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (pack_err) begin
                        err_d = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (bus.cmd_kind == KIND_LI && !li_fits && li_need_lo) begin
                            li_latch = 1'b1;
                            state_d  = ST_LI_LO;
                        end
                    end
                end
            end
            ST_LI_LO: begin
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Output slot: load on a free slot, drain when the consumer takes the word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the word register is reset as well so instr reads zero out of reset.
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            enc_err_q     <= 1'b0;
        end else begin
            enc_err_q <= err_d;
            if (load) begin
                instr_q       <= pack_word;
                instr_valid_q <= 1'b1;
            end else if (bus.instr_ready) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    // Pending LI low half, captured when the LUI is emitted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            li_rd_q <= '0;
            li_lo_q <= '0;
        end else if (li_latch) begin
            li_rd_q <= bus.cmd_rd;
            li_lo_q <= bus.cmd_immed[11:0];
        end
    end

    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.enc_err     = enc_err_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Assembles RV32I instruction words from decoded-form command fields (kind, ALU funct code, rs1/rs2/rd, 32-bit immediate). It is the inverse of the core's instruction decode path.
- Sits between the self-test/program-loader sequencer and instruction memory or the fetch-injection port.
- Expands the LI pseudo-op into a LUI/ADDI pair or a single instruction.
- Output is a registered valid/ready stream.

Parameters:
- N, 32, data/immediate width; the encoding is fixed at 32 bits.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid and ready are both high
- cmd_kind  in  4  ALU_REG=0, ALU_IMM=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, LI=8, ECOL=9
- cmd_alu_funct  in  ALU_FUNCT_WIDTH  ALU function code, used for ALU_REG and ALU_IMM
- cmd_funct3  in  3  funct3 for LOAD, STORE and BRANCH
- cmd_rs1, cmd_rs2, cmd_rd  in  5 each  register indices
- cmd_immed  in  N  immediate; byte offset for branches and jumps
- instr_valid  out  1  instr holds a word
- instr_ready  in  1  consumer accepts the word
- instr  out  32  encoded instruction
- enc_err  out  1  one-cycle pulse: the command was rejected and no word was emitted

Behaviour:
- Reset: instr_valid=0, instr=0, enc_err=0, state=IDLE. cmd_ready goes to 1 once reset is released.
- Output register:
  - loads when it is empty or when instr_ready=1 in the same cycle.
  - holds instr stable while instr_valid=1 and instr_ready=0.
- cmd_ready = (state==IDLE) && (!instr_valid || instr_ready).
- Latency: accept at cycle t gives instr_valid at t+1. Full throughput is one word per cycle.
- State machine:
  - IDLE: on accept, encode the command.
    - LI with a two-word result emits LUI and goes to LI_LO.
    - Every other command emits one word, or raises enc_err, and stays in IDLE.
  - LI_LO: once the output slot frees, emit ADDI rd,rd,lo and return to IDLE. The latched rd and lo are held in internal registers.
- ALU mapping:
  - ALU_FUNCT to funct3/funct7: SUB gives funct3 0 with funct7 0100000; SRA gives funct3 101 with funct7 0100000; all others have funct7 0.
  - ALU_IMM with SUB is an error.
  - ALU_IMM shifts use imm[4:0] and require cmd_immed[31:5]==0.
- Immediate range checks (failure gives enc_err, no word, command consumed):
  - I/S type: signed 12-bit.
  - B type: signed 13-bit, even.
  - J type: signed 21-bit, even.
  - LUI: cmd_immed[11:0]==0; the upper 20 bits are encoded.
- LI expansion:
  - If cmd_immed fits in signed 12 bits: emit ADDI rd,x0,imm.
  - Otherwise lo = sext(imm[11:0]) and hi = imm[31:12] + imm[11], modulo 2^20. Emit LUI rd,hi, then ADDI only if lo != 0.
- rd=0 is encoded as given, with no special casing.
- Undefined cmd_kind, or ECOL with the feature disabled, is an error.
- Reset mid-LI: state returns to IDLE, instr_valid=0, and no ADDI is emitted.
- enc_err and a valid output word never coincide for the same command.

Optional Feature:
- XEDGCOL_EN
  - Defined: cmd_kind ECOL encodes the Xedgcol ECOL instruction. The opcode is taken from the shared Xedgcol opcode define; rs1 and rs2 go in their standard fields, rd=0 and funct3=0.
  - Undefined: ECOL raises enc_err.

Decomposition:
- Shared package: cmd_kind enumeration, opcode constants, funct3/funct7 constants, ALU_FUNCT codes. These are the same defines the decoder uses, so encode and decode cannot drift.
- One sub-module, instr_field_pack: combinational packing of opcode, fields and immediate per format (R/I/S/B/U/J) into a 32-bit word, plus the range-check flag.
- The top level holds the FSM, LI expansion and the output register.

Test Plan:
- ALU_REG ADD rs1=1 rs2=2 rd=3 -> instr=0x002081B3 one cycle after accept. ALU_REG SUB rs1=2 rs2=3 rd=1 -> 0x403100B3.
- LI rd=5 imm=0x12345FFF -> two words, 0x123462B7 then 0xFFF28293. cmd_ready stays low during LI_LO.
- LI rd=1 imm=-5 -> single word 0xFFB00093. LI rd=2 imm=0x1000 -> single word 0x00001137, no ADDI.
- BRANCH funct3=000 rs1=1 rs2=2 imm=8 -> 0x00208463. Same command with imm=7 or imm=4096 -> enc_err pulse, instr_valid stays 0.
- Back-pressure: hold instr_ready=0 for 5 cycles after the ADD word -> instr stable, cmd_ready=0. Release -> next queued command is encoded without loss or duplication.
- Reset asserted during LI_LO -> instr_valid=0 immediately. After release, no ADDI appears and the next command encodes normally.
